waveform_pixel_src: RTL and testbench
=====================================

Name: waveform_pixel_src

Overview:
- Upstream pixel source for the 0.96" ST7735 SPI LCD command/pixel sequencer.
- Produces one full memory-write frame of RGB565 pixels in raster order over a valid/ready stream: 80 columns x 160 rows, 12800 pixels.
- The frame shows a scrolling triangle-wave trace. Rows are the time axis; the column gives amplitude.
- The LCD sequencer pops one pixel per 16-bit SPI transfer after its 0x2C command.

Parameters:
- WIDTH, 80, pixels per row (CASET window 0x1A..0x69).
- HEIGHT, 160, rows per frame (RASET window 0x01..0xA0).
- FG_COLOR, 16'hFFFF, RGB565 trace colour.
- BG_COLOR, 16'h0000, RGB565 background colour.
- SCROLL, 8'd4, phase advance added to frame_phase at each frame end.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST_N  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- START  in  1  one-cycle pulse: begin a frame. Sampled only in IDLE.
- STEP  in  8  phase increment per row. Latched at accepted START.
- PIX_DATA  out  16  RGB565 pixel, MSB first on the wire.
- PIX_VALID  out  1  PIX_DATA is valid.
- PIX_READY  in  1  consumer accepts PIX_DATA.
- BUSY  out  1  high from accepted START until FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset (async assert, sync release): state=IDLE; PIX_VALID=0; PIX_DATA=0; BUSY=0; FRAME_DONE=0; col=0; row=0; row_phase=0; frame_phase=0; trace_col=0; step_q=0.
- Transfer occurs on any CLK edge with PIX_VALID && PIX_READY.
- While PIX_VALID=1 and PIX_READY=0, PIX_DATA and PIX_VALID hold stable.
- PIX_VALID never drops without a transfer, except via reset.

State machine (IDLE, LOAD_ROW, STREAM, DONE):
- IDLE: on START, latch step_q=STEP, row_phase=frame_phase, col=0, row=0, BUSY=1, go to LOAD_ROW. START in any other state is ignored.
- LOAD_ROW: compute trace_col from row_phase, then go to STREAM. In the same cycle register the pixel for (0,row) and set PIX_VALID=1. PIX_VALID therefore rises exactly 2 cycles after START is sampled.
- STREAM, per transfer:
  - If col<WIDTH-1: col+1, register the next pixel, PIX_VALID stays 1. Back-to-back transfers are allowed.
  - If col=WIDTH-1 and row<HEIGHT-1: PIX_VALID=0, col=0, row+1, row_phase=row_phase+step_q (mod 256), go to LOAD_ROW. This gives exactly one bubble cycle per row.
  - If col=WIDTH-1 and row=HEIGHT-1: PIX_VALID=0, go to DONE.
- DONE (one cycle): FRAME_DONE=1, BUSY=0, frame_phase=frame_phase+SCROLL (mod 256), go to IDLE.

Trace computation (combinational from row_phase, registered into trace_col in LOAD_ROW):
- tri[6:0] = row_phase[7] ? ~row_phase[6:0] : row_phase[6:0].
- trace_col = (tri*WIDTH)>>7, using a 7x7-bit product, giving a range of 0..79.

Pixel value:
- (c==trace_col) ? FG_COLOR : BG_COLOR.

Width rules:
- col 7 bits, row 8 bits; phases wrap mod 256 silently.

Boundary cases:
- Reset mid-frame aborts immediately: outputs return to reset values and frame_phase returns to 0.
- START coincident with DONE is ignored.

Optional Feature:
- Macro: WAVEFORM_GRID_EN.
- Defined: a non-trace pixel with col[3:0]==0 or row[3:0]==0 outputs GRID_COLOR, a 16'h18E3 localparam. Trace colour has priority over grid.
- Undefined: no grid logic is built; every non-trace pixel is BG_COLOR.

Test Plan:
- Reset: hold RST_N=0 mid-stream, then release → PIX_VALID=0, BUSY=0, FRAME_DONE=0, PIX_DATA=0. The next START begins at row 0 with frame_phase=0.
- STEP=0, frame 1, PIX_READY=1 → every row has pixel col 0 = 16'hFFFF and cols 1..79 = 16'h0000.
  - Exactly 12800 transfers and 159 single-cycle bubbles.
  - FRAME_DONE pulses once, 1 cycle after the last transfer.
  - PIX_VALID is first high 2 cycles after START.
- STEP=4, frame 1 → row 32 (phase 128, tri 127): FG at col 79. Row 16 (phase 64): FG at col 40. Row 64 (phase 0): FG at col 0.
- Scroll: second frame with STEP=0 → frame_phase=4, tri=4, FG at col 2 in every row.
- Backpressure: toggle PIX_READY randomly 50% → PIX_DATA stable while stalled. Pixel sequence identical to the no-stall run; START pulses during BUSY ignored.
- WAVEFORM_GRID_EN defined, STEP=0 → row 0: col 0 FG, cols 1..79 GRID. Row 1: col 16 GRID, col 17 BG.

Source files
------------

// File: rtl/waveform_pixel_src_if.sv
// waveform_pixel_src_if: RGB565 valid/ready pixel stream from the waveform source to the LCD sequencer.
interface waveform_pixel_src_if;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/waveform_pixel_src.sv
// waveform_pixel_src: raster-order RGB565 frame of a scrolling triangle-wave trace for the ST7735 sequencer.
// Define WAVEFORM_GRID_EN to overlay a 16-pixel grid behind the trace.
module waveform_pixel_src #(
  parameter int          WIDTH    = 80,
  parameter int          HEIGHT   = 160,
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter logic [7:0]  SCROLL   = 8'd4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  step,
  output logic                        busy,
  output logic                        frame_done,
  waveform_pixel_src_if.master        pix
);
  localparam logic [6:0] W7 = 7'(WIDTH);
  localparam logic [7:0] H8 = 8'(HEIGHT);
  typedef enum logic [1:0] {IDLE, LOAD_ROW, STREAM, DONE} state_t;
  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d, trace_col_q, trace_col_d, tri_v, tc_new;
  logic [7:0]  row_q, row_d, row_phase_q, row_phase_d, frame_phase_q, frame_phase_d, step_q, step_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
`ifdef WAVEFORM_GRID_EN
  localparam logic [15:0] GRID_COLOR = 16'h18E3;
  function automatic logic [15:0] pix_val(input logic [6:0] c, input logic [6:0] tc);
    return (c == tc) ? FG_COLOR : (c[3:0] == 4'd0 || row_q[3:0] == 4'd0) ? GRID_COLOR : BG_COLOR;
  endfunction
`else
  function automatic logic [15:0] pix_val(input logic [6:0] c, input logic [6:0] tc);
    return (c == tc) ? FG_COLOR : BG_COLOR;
  endfunction
`endif
  // Fold the phase into a 0..127 ramp, then scale to 0..WIDTH-1 with a 7x7 product.
  assign tri_v  = row_phase_q[7] ? ~row_phase_q[6:0] : row_phase_q[6:0];
  assign tc_new = 7'((14'(tri_v) * 14'(W7)) >> 7);
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    row_phase_d   = row_phase_q;
    frame_phase_d = frame_phase_q;
    trace_col_d   = trace_col_q;
    step_d        = step_q;
    data_d        = data_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        step_d      = step;
        row_phase_d = frame_phase_q;
        col_d       = 7'd0;
        row_d       = 8'd0;
        busy_d      = 1'b1;
        state_d     = LOAD_ROW;
      end
      LOAD_ROW: begin
        trace_col_d = tc_new;
        data_d      = pix_val(7'd0, tc_new);
        valid_d     = 1'b1;
        state_d     = STREAM;
      end
      STREAM: if (valid_q && pix.ready) begin
        if (col_q != W7 - 7'd1) begin
          col_d  = col_q + 7'd1;
          data_d = pix_val(col_q + 7'd1, trace_col_q);
        end else if (row_q != H8 - 8'd1) begin
          valid_d     = 1'b0;
          col_d       = 7'd0;
          row_d       = row_q + 8'd1;
          row_phase_d = row_phase_q + step_q;
          state_d     = LOAD_ROW;
        end else begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        frame_phase_d = frame_phase_q + SCROLL;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      row_phase_q   <= '0;
      frame_phase_q <= '0;
      trace_col_q   <= '0;
      step_q        <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_phase_q   <= row_phase_d;
      frame_phase_q <= frame_phase_d;
      trace_col_q   <= trace_col_d;
      step_q        <= step_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end
  assign pix.data   = data_q;
  assign pix.valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_waveform_pixel_src.sv
// tb_waveform_pixel_src: directed frame-level checks of the waveform pixel source.
module tb_waveform_pixel_src;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] step = 8'd0;
  logic       busy, frame_done;
  waveform_pixel_src_if pif();
  waveform_pixel_src dut (.clk(clk), .rst_n(rst_n), .start(start), .step(step), .busy(busy), .frame_done(frame_done), .pix(pif.master));
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0;
  int ntx, nbub, stab_err, errs;
  logic lat0, lat1, done1, done2, busy1;
  logic [15:0] img [160][80];
  function automatic logic [15:0] exp_pix(int c, int r, int tc);
`ifdef WAVEFORM_GRID_EN
    return (c == tc) ? 16'hFFFF : (c % 16 == 0 || r % 16 == 0) ? 16'h18E3 : 16'h0000;
`else
    return (c == tc) ? 16'hFFFF : 16'h0000;
`endif
  endfunction
  function automatic int img_errs(int tc);
    int n = 0;
    for (int r = 0; r < 160; r++)
      for (int c = 0; c < 80; c++)
        if (img[r][c] !== exp_pix(c, r, tc)) n++;
    return n;
  endfunction
  task automatic run_frame(input logic [7:0] st, input bit stall);
    int cyc = 0;
    bit held = 0;
    logic [15:0] pd = '0;
    ntx = 0; nbub = 0; stab_err = 0;
    step = st; start = 1'b1; pif.ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat0 = pif.valid;
    @(posedge clk); #1;
    lat1 = pif.valid;
    while (ntx < 12800 && cyc < 40000) begin
      if (held && !(pif.valid === 1'b1 && pif.data === pd)) stab_err++;
      pif.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = stall && (cyc % 97 == 5);
      held = pif.valid && !pif.ready;
      pd = pif.data;
      if (pif.valid && pif.ready) begin
        img[ntx / 80][ntx % 80] = pif.data;
        ntx++;
      end else if (!pif.valid) nbub++;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    done1 = frame_done; busy1 = busy;
    @(posedge clk); #1;
    done2 = frame_done;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_init;
    total_n++; if (pif.valid !== 1'b0) $display("FAIL init_valid got %b exp 0", pif.valid); else pass_n++;
    total_n++; if (pif.data !== 16'h0000) $display("FAIL init_data got %h exp 0000", pif.data); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL init_busy got %b exp 0", busy); else pass_n++;
    total_n++; if (frame_done !== 1'b0) $display("FAIL init_done got %b exp 0", frame_done); else pass_n++;
  endtask
  task automatic test_step4;
    run_frame(8'd4, 0);
    total_n++; if (ntx !== 12800) $display("FAIL s4_transfers got %0d exp 12800", ntx); else pass_n++;
    total_n++; if (img[32][79] !== 16'hFFFF) $display("FAIL s4_row32_col79 got %h exp ffff", img[32][79]); else pass_n++;
    total_n++; if (img[32][78] === 16'hFFFF) $display("FAIL s4_row32_col78 got %h exp not ffff", img[32][78]); else pass_n++;
    total_n++; if (img[16][40] !== 16'hFFFF) $display("FAIL s4_row16_col40 got %h exp ffff", img[16][40]); else pass_n++;
    total_n++; if (img[64][0] !== 16'hFFFF) $display("FAIL s4_row64_col0 got %h exp ffff", img[64][0]); else pass_n++;
  endtask
  task automatic test_scroll;
    run_frame(8'd0, 0);
    errs = img_errs(2);
    total_n++; if (ntx !== 12800) $display("FAIL scroll_transfers got %0d exp 12800", ntx); else pass_n++;
    total_n++; if (errs !== 0) $display("FAIL scroll_pixels got %0d bad exp 0", errs); else pass_n++;
  endtask
  task automatic test_reset_mid;
    step = 8'd0; start = 1'b1; pif.ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_n++; if (pif.valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", pif.valid); else pass_n++;
    total_n++; if (pif.data !== 16'h0000) $display("FAIL rst_data got %h exp 0000", pif.data); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_n++;
    total_n++; if (frame_done !== 1'b0) $display("FAIL rst_done got %b exp 0", frame_done); else pass_n++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_step0;
    run_frame(8'd0, 0);
    errs = img_errs(0);
    total_n++; if (lat0 !== 1'b0) $display("FAIL lat_cycle1 got %b exp 0", lat0); else pass_n++;
    total_n++; if (lat1 !== 1'b1) $display("FAIL lat_cycle2 got %b exp 1", lat1); else pass_n++;
    total_n++; if (ntx !== 12800) $display("FAIL s0_transfers got %0d exp 12800", ntx); else pass_n++;
    total_n++; if (nbub !== 159) $display("FAIL s0_bubbles got %0d exp 159", nbub); else pass_n++;
    total_n++; if (errs !== 0) $display("FAIL s0_pixels got %0d bad exp 0", errs); else pass_n++;
    total_n++; if (done1 !== 1'b1) $display("FAIL done_pulse got %b exp 1", done1); else pass_n++;
    total_n++; if (done2 !== 1'b0) $display("FAIL done_width got %b exp 0", done2); else pass_n++;
    total_n++; if (busy1 !== 1'b0) $display("FAIL busy_at_done got %b exp 0", busy1); else pass_n++;
`ifdef WAVEFORM_GRID_EN
    total_n++; if (img[0][5] !== 16'h18E3) $display("FAIL grid_r0c5 got %h exp 18e3", img[0][5]); else pass_n++;
    total_n++; if (img[1][16] !== 16'h18E3) $display("FAIL grid_r1c16 got %h exp 18e3", img[1][16]); else pass_n++;
    total_n++; if (img[1][17] !== 16'h0000) $display("FAIL grid_r1c17 got %h exp 0000", img[1][17]); else pass_n++;
`else
    total_n++; if (img[1][16] !== 16'h0000) $display("FAIL nogrid_r1c16 got %h exp 0000", img[1][16]); else pass_n++;
`endif
  endtask
  task automatic test_backpressure;
    run_frame(8'd0, 1);
    errs = img_errs(2);
    total_n++; if (ntx !== 12800) $display("FAIL bp_transfers got %0d exp 12800", ntx); else pass_n++;
    total_n++; if (stab_err !== 0) $display("FAIL bp_stable got %0d changes exp 0", stab_err); else pass_n++;
    total_n++; if (nbub < 159) $display("FAIL bp_bubbles got %0d exp >=159", nbub); else pass_n++;
    total_n++; if (errs !== 0) $display("FAIL bp_pixels got %0d bad exp 0", errs); else pass_n++;
    total_n++; if (done1 !== 1'b1) $display("FAIL bp_done got %b exp 1", done1); else pass_n++;
  endtask
  initial begin
    pif.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset_init();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_step4();
    test_scroll();
    test_reset_mid();
    test_step0();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
  initial begin
    #1_200_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
